async_fifo_rd_stream: RTL and testbench

Read-side adapter for the dual-clock FIFO, the consumer counterpart of its write interface. It sits in the read clock domain and pops words through the FIFO's `rempty`/`rinc`/`rdata` read port. It re-presents them as a registered valid/ready stream with a 2-entry skid buffer, sustaining one word per cycle with no combinational path from `m_ready` to `rinc`. It also provides a synchronous flush and a handshake beat counter.

---
 rtl/async_fifo_rd_stream.sv | 108 ++++++++++
 tb/tb_async_fifo_rd_stream.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/async_fifo_rd_stream.sv
// Read-side adapter for the dual-clock FIFO.
// Pops the FIFO into a registered valid/ready stream with a 2-entry skid.
module async_fifo_rd_stream #(
  parameter int DSIZE = 8,
  parameter int CNT_W = 16
) (
  input  logic             rclk,
  input  logic             rrst,
  input  logic             rempty,
  input  logic [DSIZE-1:0] rdata,
  output logic             rinc,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [DSIZE-1:0] m_data,
  input  logic             flush,
  output logic [CNT_W-1:0] beat_cnt
);

  typedef enum logic [2:0] {
    EMPTY = 3'b001,
    ONE   = 3'b010,
    TWO   = 3'b100
  } state_t;

  state_t           state;
  state_t           state_n;
  logic [DSIZE-1:0] skid;
  logic             push;
  logic             pop;
  logic             load_m;
  logic             load_s;
  logic             from_skid;

  // Pop strobe depends only on registers and FIFO-side inputs, never m_ready
  assign push = !rempty && !flush && !rrst && (state != TWO);
  assign rinc = push;
  assign pop  = m_valid && m_ready;

  // Next-state and load selection; flush overrides every transition
  always_comb begin
    state_n   = state;
    load_m    = 1'b0;
    load_s    = 1'b0;
    from_skid = 1'b0;
    if (flush) begin
      state_n = EMPTY;
    end else begin
      unique case (1'b1)
        state[0]: begin
          if (push) begin
            load_m  = 1'b1;
            state_n = ONE;
          end
        end
        state[1]: begin
          if (push && pop) begin
            load_m = 1'b1;
          end else if (push) begin
            load_s  = 1'b1;
            state_n = TWO;
          end else if (pop) begin
            state_n = EMPTY;
          end
        end
        state[2]: begin
          if (pop) begin
            load_m    = 1'b1;
            from_skid = 1'b1;
            state_n   = ONE;
          end
        end
        default: state_n = EMPTY;
      endcase
    end
  end

  // State register with m_valid kept as a decoded flop
  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      state   <= EMPTY;
      m_valid <= 1'b0;
    end else begin
      state   <= state_n;
      m_valid <= (state_n != EMPTY);
    end
  end

  // Output and skid data registers
  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      m_data <= '0;
      skid   <= '0;
    end else begin
      if (load_m) m_data <= from_skid ? skid : rdata;
      if (load_s) skid <= rdata;
    end
  end

  // Completed handshakes, including one taken during a flush
  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      beat_cnt <= '0;
    end else if (pop) begin
      beat_cnt <= beat_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_async_fifo_rd_stream.sv
// Bench for async_fifo_rd_stream: FIFO model, in-flight word queue
// and a monitor that checks every presented word and beat count.
module tb_async_fifo_rd_stream;

  logic        rclk = 1'b0;
  logic        rrst = 1'b1;
  logic        rempty = 1'b1;
  logic [7:0]  rdata = 8'h00;
  logic        m_ready = 1'b0;
  logic        flush = 1'b0;
  logic        rinc;
  logic        m_valid;
  logic [7:0]  m_data;
  logic [15:0] beat_cnt;
  logic        rinc_w;
  logic        m_valid_w;
  logic [7:0]  m_data_w;
  logic [3:0]  beat_cnt_w;

  int vectors = 0;
  int errors = 0;

  logic [7:0]  fifo_q[$];
  logic [7:0]  exp_q[$];
  logic [31:0] beats = 0;
  int          rinc_hi = 0;

  always #5 rclk = ~rclk;

  async_fifo_rd_stream #(.DSIZE(8), .CNT_W(16)) dut (
    .rclk(rclk), .rrst(rrst), .rempty(rempty), .rdata(rdata),
    .rinc(rinc), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .flush(flush), .beat_cnt(beat_cnt)
  );

  async_fifo_rd_stream #(.DSIZE(8), .CNT_W(4)) dut_w (
    .rclk(rclk), .rrst(rrst), .rempty(rempty), .rdata(rdata),
    .rinc(rinc_w), .m_valid(m_valid_w), .m_ready(m_ready),
    .m_data(m_data_w), .flush(flush), .beat_cnt(beat_cnt_w)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: drive at negedge, check rinc, then account the edge
  task automatic cycle(input bit rdy, input bit fl);
    bit         exp_rinc;
    bit         did_push;
    logic [7:0] word;
    @(negedge rclk);
    m_ready = rdy;
    flush   = fl;
    rempty  = (fifo_q.size() == 0);
    rdata   = rempty ? 8'h00 : fifo_q[0];
    #3;
    exp_rinc = !rempty && !fl && (exp_q.size() < 2);
    chk("rinc", rinc, exp_rinc);
    did_push = rinc;
    word = rdata;
    @(posedge rclk);
    #1;
    if (fl) exp_q.delete();
    if (did_push) begin
      rinc_hi++;
      exp_q.push_back(word);
      if (fifo_q.size() != 0) void'(fifo_q.pop_front());
    end
  endtask

  // Monitor: sample 1 time unit before each rising edge
  initial begin
    forever begin
      @(negedge rclk);
      #4;
      chk("beat_cnt", beat_cnt, {16'h0, beats[15:0]});
      chk("beat_cnt_w4", beat_cnt_w, {28'h0, beats[3:0]});
      chk("m_valid", m_valid, exp_q.size() != 0);
      chk("occupancy_le_2", exp_q.size() <= 2, 1);
      if (m_valid && exp_q.size() != 0) begin
        chk("m_data", m_data, exp_q[0]);
        if (m_ready) begin
          void'(exp_q.pop_front());
          beats++;
        end
      end
    end
  end

  initial begin
    logic [31:0] b0;
    bit [3:0]    pat;
    pat = 4'b1001;

    // Reset then idle with an empty FIFO
    repeat (3) @(negedge rclk);
    rrst = 1'b0;
    repeat (10) cycle(1'b0, 1'b0);

    // Streaming 0x01..0x10 with m_ready held high
    for (int i = 1; i <= 16; i++) fifo_q.push_back(8'(i));
    rinc_hi = 0;
    repeat (20) cycle(1'b1, 1'b0);
    chk("stream_rinc_cycles", rinc_hi, 16);
    chk("stream_beats", beat_cnt, 16);

    // 17th handshake wraps the 4-bit counter to 1
    fifo_q.push_back(8'h11);
    repeat (3) cycle(1'b1, 1'b0);
    chk("wrap_cnt4", beat_cnt_w, 1);

    // Backpressure with m_ready pattern 1,0,0,1
    for (int i = 0; i < 8; i++) fifo_q.push_back(8'hA0 + 8'(i));
    for (int i = 0; i < 32; i++) cycle(pat[i % 4], 1'b0);

    // Flush while holding two words and a third waits in the FIFO
    fifo_q.push_back(8'h55);
    fifo_q.push_back(8'h66);
    fifo_q.push_back(8'h77);
    repeat (3) cycle(1'b0, 1'b0);
    chk("pre_flush_data", m_data, 8'h55);
    b0 = beats;
    cycle(1'b0, 1'b1);
    chk("flush_valid", m_valid, 0);
    chk("flush_beats", beat_cnt, b0);
    cycle(1'b0, 1'b0);
    chk("post_flush_valid", m_valid, 1);
    chk("post_flush_data", m_data, 8'h77);

    // Flush together with a handshake
    b0 = beats;
    cycle(1'b1, 1'b1);
    chk("flush_hs_beats", beat_cnt, b0 + 1);
    chk("flush_hs_valid", m_valid, 0);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 2) != 0 && fifo_q.size() < 64)
        fifo_q.push_back(8'($urandom));
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0);
    end

    // Asynchronous reset in the middle of a cycle
    fifo_q.push_back(8'h3C);
    repeat (2) cycle(1'b0, 1'b0);
    @(negedge rclk);
    #2;
    rrst = 1'b1;
    #1;
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_beat_cnt", beat_cnt, 0);
    chk("rst_rinc", rinc, 0);
    fifo_q.delete();
    exp_q.delete();
    beats  = 0;
    rempty = 1'b1;
    @(negedge rclk);
    rrst = 1'b0;
    fifo_q.push_back(8'hC3);
    repeat (4) cycle(1'b1, 1'b0);
    chk("after_rst_beats", beat_cnt, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
